// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the UART bridge.
package uart_bridge_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_bridge_fifo.sv
// First-word-fall-through FIFO with registered full/empty flags.
// The head reads as zero while the FIFO is empty.
module uart_bridge_fifo
  import uart_bridge_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned WIDTH      = DATA_BITS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_full;
  logic             r_empty;
  logic             w_push_ok;
  logic             w_pop_ok;

  // Full rejects a push, empty ignores a pop.
  assign w_push_ok = i_push & ~r_full;
  assign w_pop_ok  = i_pop & ~r_empty;

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers, occupancy and flags; pointers wrap naturally at the depth.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(FIFO_DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clock) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head  = r_empty ? '0 : r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/uart_bridge.sv
// 8N1 UART front-end for the MIPS core serial window: TX/RX FIFOs plus
// bit-serial transmitter and receiver.
// Build option: UART_BRIDGE_LOOPBACK_EN routes the internal transmit bit to
// the receiver, ties the tx pin high and ignores the rx pin.
module uart_bridge
  import uart_bridge_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic                 tx,
  output logic [DATA_BITS-1:0] cpu_rx_data,
  output logic                 cpu_rx_valid,
  input  logic                 cpu_rden,
  input  logic [DATA_BITS-1:0] cpu_tx_data,
  input  logic                 cpu_wren,
  output logic                 cpu_tx_ready,
  output logic                 rx_overrun
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] IDX_LAST  = BIT_W'(DATA_BITS - 1);

  // ---------------- TX path ----------------
  tx_state_t            r_tx_state, w_tx_state_nxt;
  logic [CNT_W-1:0]     r_tx_cnt, w_tx_cnt_nxt;
  logic [BIT_W-1:0]     r_tx_idx, w_tx_idx_nxt;
  logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_nxt;
  logic                 r_tx_line, w_tx_line_nxt;
  logic                 w_tx_pop;
  logic [DATA_BITS-1:0] w_tx_head;
  logic                 w_tx_full;
  logic                 w_tx_empty;

  uart_bridge_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (DATA_BITS)
  ) u_tx_fifo (
    .clock       (clock),
    .reset       (reset),
    .i_push      (cpu_wren),
    .i_push_data (cpu_tx_data),
    .i_pop       (w_tx_pop),
    .o_head      (w_tx_head),
    .o_full      (w_tx_full),
    .o_empty     (w_tx_empty)
  );

  // TX next state: load from FIFO in idle, then start, 8 data bits, stop.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_tx_idx_nxt   = r_tx_idx;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_line_nxt  = 1'b1;
    w_tx_pop       = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (!w_tx_empty) begin
          w_tx_pop       = 1'b1;
          w_tx_shift_nxt = w_tx_head;
          w_tx_cnt_nxt   = '0;
          w_tx_state_nxt = TX_START;
        end
      end
      TX_START: begin
        w_tx_line_nxt = 1'b0;
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_cnt_nxt   = '0;
          w_tx_idx_nxt   = '0;
          w_tx_state_nxt = TX_DATA;
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + CNT_W'(1);
        end
      end
      TX_DATA: begin
        w_tx_line_nxt = r_tx_shift[0];
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_cnt_nxt   = '0;
          w_tx_shift_nxt = {1'b0, r_tx_shift[DATA_BITS-1:1]};
          if (r_tx_idx == IDX_LAST) w_tx_state_nxt = TX_STOP;
          else                      w_tx_idx_nxt   = r_tx_idx + BIT_W'(1);
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + CNT_W'(1);
        end
      end
      TX_STOP: begin
        w_tx_line_nxt = 1'b1;
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_cnt_nxt   = '0;
          w_tx_state_nxt = TX_IDLE;
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + CNT_W'(1);
        end
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
  end

  // TX state and registered line bit (line lags the state by one cycle).
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_shift <= '0;
      r_tx_line  <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_idx   <= w_tx_idx_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx_line  <= w_tx_line_nxt;
    end
  end

  // ---------------- RX path ----------------
  logic                 w_rx_in;
  logic [1:0]           r_rx_sync;
  logic                 w_rx_s;
  logic                 r_rx_prev;
  rx_state_t            r_rx_state, w_rx_state_nxt;
  logic [CNT_W-1:0]     r_rx_cnt, w_rx_cnt_nxt;
  logic [BIT_W-1:0]     r_rx_idx, w_rx_idx_nxt;
  logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift_nxt;
  logic                 w_rx_push;
  logic                 w_rx_full;
  logic                 w_rx_empty;
  logic                 r_overrun;

`ifdef UART_BRIDGE_LOOPBACK_EN
  assign w_rx_in = r_tx_line;
  assign tx      = 1'b1;
`else
  assign w_rx_in = rx;
  assign tx      = r_tx_line;
`endif

  assign w_rx_s = r_rx_sync[1];

  // Two-flop synchronizer plus previous-sample flop for edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rx_sync <= 2'b11;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_sync <= {r_rx_sync[0], w_rx_in};
      r_rx_prev <= w_rx_s;
    end
  end

  uart_bridge_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (DATA_BITS)
  ) u_rx_fifo (
    .clock       (clock),
    .reset       (reset),
    .i_push      (w_rx_push),
    .i_push_data (r_rx_shift),
    .i_pop       (cpu_rden),
    .o_head      (cpu_rx_data),
    .o_full      (w_rx_full),
    .o_empty     (w_rx_empty)
  );

  // RX next state: edge detect, mid-start check, centre-sampled bits, stop.
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt;
    w_rx_idx_nxt   = r_rx_idx;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_push      = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (r_rx_prev && !w_rx_s) begin
          w_rx_cnt_nxt   = '0;
          w_rx_state_nxt = RX_START;
        end
      end
      RX_START: begin
        if (r_rx_cnt == HALF_LAST) begin
          w_rx_cnt_nxt = '0;
          w_rx_idx_nxt = '0;
          w_rx_state_nxt = w_rx_s ? RX_IDLE : RX_DATA;
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (r_rx_cnt == BIT_LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_shift_nxt = {w_rx_s, r_rx_shift[DATA_BITS-1:1]};
          if (r_rx_idx == IDX_LAST) w_rx_state_nxt = RX_STOP;
          else                      w_rx_idx_nxt   = r_rx_idx + BIT_W'(1);
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (r_rx_cnt == BIT_LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_push      = w_rx_s;
          w_rx_state_nxt = RX_IDLE;
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + CNT_W'(1);
        end
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  // RX state registers and sticky overrun flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_shift <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_idx   <= w_rx_idx_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      r_overrun  <= r_overrun | (w_rx_push & w_rx_full);
    end
  end

  assign cpu_rx_valid = ~w_rx_empty;
  assign cpu_tx_ready = ~w_tx_full;
  assign rx_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_bridge.sv
// Scoreboard bench for uart_bridge: expected bytes are queued at stimulus
// time; independent monitors decode the tx line and the CPU read port.
module tb_uart_bridge;

  localparam int unsigned CPB   = 16;
  localparam int unsigned DEPTH = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx;
  logic       tx;
  logic [7:0] cpu_rx_data;
  logic       cpu_rx_valid;
  logic       cpu_rden;
  logic [7:0] cpu_tx_data;
  logic       cpu_wren;
  logic       cpu_tx_ready;
  logic       rx_overrun;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  logic       model_overrun = 1'b0;
  int         tx_frames = 0;
  logic       tx_busy = 1'b0;

  uart_bridge #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rx           (rx),
    .tx           (tx),
    .cpu_rx_data  (cpu_rx_data),
    .cpu_rx_valid (cpu_rx_valid),
    .cpu_rden     (cpu_rden),
    .cpu_tx_data  (cpu_tx_data),
    .cpu_wren     (cpu_wren),
    .cpu_tx_ready (cpu_tx_ready),
    .rx_overrun   (rx_overrun)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Advance n clocks; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Ideal 8N1 line waveform t cycles after the accepting write edge.
  function automatic logic exp_tx_bit(input logic [7:0] b, input int t);
    int k;
    if (t < 2) return 1'b1;
    k = (t - 2) / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  // Drive one frame on rx and update the receive model.
  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
    rx = 1'b1;
    if (stop_bit) begin
      if (rx_exp.size() < DEPTH) rx_exp.push_back(b);
      else                       model_overrun = 1'b1;
    end
    tick(CPB);
  endtask

  // Pop the RX FIFO until empty; the monitor checks every popped byte.
  task automatic drain_rx();
    int n;
    int exp_n;
    n = 0;
    exp_n = rx_exp.size();
    for (int k = 0; k < 4 * DEPTH; k++) begin
      if (!cpu_rx_valid) break;
      cpu_rden = 1'b1;
      tick(1);
      cpu_rden = 1'b0;
      tick(1);
      n++;
    end
    check("rx_drain_count", n, exp_n);
    check("rx_valid_after_drain", cpu_rx_valid, 1'b0);
    check("rx_data_zero_when_empty", cpu_rx_data, 8'h00);
  endtask

  task automatic wait_tx_drain();
    int k;
    k = 0;
    while ((tx_exp.size() != 0 || tx_busy) && k < 20000) begin
      tick(1);
      k++;
    end
    check("tx_drain_in_time", (tx_exp.size() == 0 && !tx_busy), 1'b1);
  endtask

  // TX monitor: decode each frame at bit centres and compare with the queue.
  initial begin : tx_mon
    logic [7:0] b;
    logic       s0;
    logic       sp;
    logic [7:0] e;
    forever begin
      @(negedge clock);
      if (reset === 1'b0 && tx === 1'b0) begin
        tx_busy = 1'b1;
        repeat (CPB / 2) @(negedge clock);
        s0 = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clock);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clock);
        sp = tx;
        tx_frames++;
        if (tx_exp.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL tx_unexpected_frame: got %02h expected no frame", b);
        end else begin
          e = tx_exp.pop_front();
          check("tx_frame", {s0, b, sp}, {1'b0, e, 1'b1});
        end
        tx_busy = 1'b0;
      end
    end
  end

  // RX monitor: every accepted pop must present the next expected byte.
  initial begin : rx_mon
    forever begin
      @(negedge clock);
      if (reset === 1'b0 && cpu_rden === 1'b1 && cpu_rx_valid === 1'b1) begin
        if (rx_exp.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL rx_unexpected_byte: got %02h expected none", cpu_rx_data);
        end else begin
          check("rx_data", cpu_rx_data, rx_exp.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [169:0] got_w;
    logic [169:0] exp_w;
    logic [7:0]   b;
    int           wr_cyc;
    int           frames0;
    int           n;
    int           k;

    reset = 1'b1;
    rx = 1'b1;
    cpu_rden = 1'b0;
    cpu_wren = 1'b0;
    cpu_tx_data = 8'h00;
    tick(3);
    reset = 1'b0;

    // Idle after reset.
    tick(200);
    check("reset_tx", tx, 1'b1);
    check("reset_rx_valid", cpu_rx_valid, 1'b0);
    check("reset_rx_data", cpu_rx_data, 8'h00);
    check("reset_tx_ready", cpu_tx_ready, 1'b1);
    check("reset_overrun", rx_overrun, 1'b0);

    // Single write of 0xA5: exact waveform including latency and frame length.
    b = 8'hA5;
    tx_exp.push_back(b);
    cpu_tx_data = b;
    cpu_wren = 1'b1;
    tick(1);
    cpu_wren = 1'b0;
    wr_cyc = cyc;
    for (int t = 1; t <= 170; t++) begin
      tick(1);
      got_w[t-1] = tx;
      exp_w[t-1] = exp_tx_bit(b, cyc - wr_cyc);
    end
    check("tx_a5_waveform", 192'(got_w), 192'(exp_w));
    wait_tx_drain();

    // Single received byte 0x3C, then one pop empties the FIFO.
    send_rx(8'h3C, 1'b1);
    check("rx_3c_valid", cpu_rx_valid, 1'b1);
    check("rx_3c_data", cpu_rx_data, 8'h3C);
    cpu_rden = 1'b1;
    tick(1);
    cpu_rden = 1'b0;
    tick(1);
    check("rx_3c_valid_after_pop", cpu_rx_valid, 1'b0);

    // Short low glitch is rejected.
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(3 * CPB);
    check("rx_glitch_no_push", cpu_rx_valid, 1'b0);

    // Framing error: byte discarded without flagging overrun.
    send_rx(8'h5A, 1'b0);
    check("rx_framing_no_push", cpu_rx_valid, 1'b0);
    check("rx_framing_no_overrun", rx_overrun, 1'b0);

    // Random receive batches that fit in the FIFO.
    for (int bt = 0; bt < 3; bt++) begin
      n = $urandom_range(1, DEPTH);
      for (int j = 0; j < n; j++) send_rx(8'($urandom), 1'b1);
      drain_rx();
      check("rx_batch_overrun", rx_overrun, model_overrun);
    end

    // Burst of 10 writes on an idle transmitter: one byte moves into the
    // shifter a cycle after the first write, so DEPTH+1 are accepted.
    frames0 = tx_frames;
    for (int i = 0; i < DEPTH + 2; i++) begin
      cpu_tx_data = 8'($urandom);
      cpu_wren = 1'b1;
      if (i < DEPTH + 1) tx_exp.push_back(cpu_tx_data);
      tick(1);
      if (i == DEPTH - 1) check("tx_ready_before_full", cpu_tx_ready, 1'b1);
      if (i == DEPTH)     check("tx_ready_when_full", cpu_tx_ready, 1'b0);
    end
    cpu_wren = 1'b0;
    wait_tx_drain();
    tick(200);
    check("tx_burst_frame_count", tx_frames - frames0, DEPTH + 1);
    check("tx_ready_after_drain", cpu_tx_ready, 1'b1);

    // Random writes with random gaps, gated by the ready handshake.
    for (int i = 0; i < 24; i++) begin
      tick($urandom_range(0, 3));
      k = 0;
      while (!cpu_tx_ready && k < 5000) begin
        tick(1);
        k++;
      end
      check("tx_ready_wait", cpu_tx_ready, 1'b1);
      b = 8'($urandom);
      tx_exp.push_back(b);
      cpu_tx_data = b;
      cpu_wren = 1'b1;
      tick(1);
      cpu_wren = 1'b0;
    end
    wait_tx_drain();

    // Overrun: DEPTH+1 frames without reading; the last one is dropped.
    for (int j = 0; j < DEPTH + 1; j++) send_rx(8'($urandom), 1'b1);
    check("rx_overrun_set", rx_overrun, model_overrun);
    check("rx_overrun_model", model_overrun, 1'b1);
    drain_rx();
    check("rx_overrun_sticky", rx_overrun, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
